// File: rtl/seq_divider_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_divider_pkg : shared state encoding and sizing for the iterative divider|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_divider_pkg;

  localparam int DIV_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// +----------------------------------------------------------------------------+
// | seq_divider_if : request/response handshake between mul/div unit and divider|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_divider_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            divw;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output flush, in_valid, divw, div_signed, dividend, divisor,
    input  out_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  flush, in_valid, divw, div_signed, dividend, divisor,
    output out_ready, out_valid, quotient, remainder
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// +----------------------------------------------------------------------------+
// | seq_divider_div_step : one restoring shift / trial-subtract / select step   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_divider_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] dmag,
  output logic [XLEN-1:0] r_next,
  output logic [XLEN-1:0] q_next
);
  logic [XLEN:0] w_r_shift;
  logic [XLEN:0] w_diff;

  // r < dmag always holds, so the shifted value stays below 2*dmag and one extra bit suffices
  assign w_r_shift = {r, q[XLEN-1]};
  assign w_diff    = w_r_shift - {1'b0, dmag};

  always_comb begin
    r_next = w_r_shift[XLEN-1:0];
    q_next = {q[XLEN-2:0], 1'b0};
    if (!w_diff[XLEN]) begin
      r_next = w_diff[XLEN-1:0];
      q_next = {q[XLEN-2:0], 1'b1};
    end
  end
endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------------+
// | seq_divider : radix-2 restoring divider, RV64M div/rem incl. 32-bit W forms |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic        clock,
  input  logic        reset,
  seq_divider_if.slave bus
);
  localparam int CNT_W = cnt_width(XLEN);
  localparam int HALF  = XLEN / 2;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_r;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_dmag;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_rem;
  logic              r_divw;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_special;
  logic              r_out_valid;

  logic [XLEN-1:0]   w_a, w_b, w_a_mag, w_b_mag, w_min;
  logic              w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0]   w_r_next, w_q_next, w_q_fix, w_r_fix;

  function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  // Operands are brought to full width first so one magnitude path serves both modes
  assign w_a = bus.divw ? {{HALF{bus.div_signed & bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]}
                        : bus.dividend;
  assign w_b = bus.divw ? {{HALF{bus.div_signed & bus.divisor[HALF-1]}}, bus.divisor[HALF-1:0]}
                        : bus.divisor;
  assign w_a_neg = bus.div_signed & w_a[XLEN-1];
  assign w_b_neg = bus.div_signed & w_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a : w_a;
  assign w_b_mag = w_b_neg ? -w_b : w_b;
  assign w_min   = bus.divw ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0  = (w_b == '0);
  assign w_ovf   = bus.div_signed & (w_a == w_min) & (w_b == '1);

  seq_divider_div_step #(.XLEN(XLEN)) u_step (
    .r      (r_r),
    .q      (r_q),
    .dmag   (r_dmag),
    .r_next (w_r_next),
    .q_next (w_q_next)
  );

  // Special cases preload their final values, so only the W-mode extension applies to them
  always_comb begin
    w_q_fix = r_q;
    w_r_fix = r_r;
    if (!r_special) begin
      if (r_q_neg) w_q_fix = -r_q;
      if (r_r_neg) w_r_fix = -r_r;
    end
    if (r_divw) begin
      w_q_fix = sext_half(w_q_fix);
      w_r_fix = sext_half(w_r_fix);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_r         <= '0;
      r_q         <= '0;
      r_dmag      <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_divw      <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_special   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (bus.in_valid) begin
            r_divw    <= bus.divw;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_dmag    <= w_b_mag;
            r_special <= w_div0 | w_ovf;
            if (w_div0) begin
              r_q     <= '1;
              r_r     <= bus.dividend;
              r_state <= FIX;
            end else if (w_ovf) begin
              r_q     <= bus.dividend;
              r_r     <= '0;
              r_state <= FIX;
            end else begin
              // W mode parks the dividend in the upper half so its MSB shifts out first
              r_q     <= bus.divw ? (w_a_mag << HALF) : w_a_mag;
              r_r     <= '0;
              r_cnt   <= bus.divw ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_r <= w_r_next;
          r_q <= w_q_next;
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        FIX: begin
          r_quot      <= w_q_fix;
          r_rem       <= w_r_fix;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_ready = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +----------------------------------------------------------------------------+
// | tb_seq_divider : directed-vector self-checking bench for seq_divider        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.XLEN(64)) bus ();

  seq_divider #(.XLEN(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Applies an op, treats the first IDLE cycle as cycle 0, checks latency and results
  task automatic run_op(input string tag, input logic w, input logic s,
                        input logic [63:0] a, input logic [63:0] b, input int exp_cyc,
                        input logic [63:0] eq, input logic [63:0] er, input logic hold);
    int cyc;
    bus.divw       = w;
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.in_valid   = 1'b1;
    cyc = 0;
    while (!bus.out_ready && cyc < 5) begin
      next_cycle();
      cyc++;
    end
    cyc = 0;
    do begin
      next_cycle();
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, 64'(bus.out_ready), 64'd0);
    end while (!bus.out_valid && cyc <= 200);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    if (!hold) begin
      bus.in_valid = 1'b0;
      next_cycle();
      check({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_ready"}, 64'(bus.out_ready), 64'd1);
    end
  endtask

  initial begin
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    reset          = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.divw       = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    next_cycle();
    next_cycle();
    check("rst_q", bus.quotient, 64'd0);
    check("rst_r", bus.remainder, 64'd0);
    check("rst_ready", 64'(bus.out_ready), 64'd1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;
    next_cycle();

    run_op("divu_100_7", 0, 0, 64'd100, 64'd7, 66, 64'd14, 64'd2, 0);
    run_op("div_m7_2", 0, 1, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("div_7_m2", 0, 1, 64'd7, -64'sd2, 66, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 0);
    run_op("div_5_0", 0, 1, 64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
    run_op("div_ovf", 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2,
           64'h8000_0000_0000_0000, 64'd0, 0);
    run_op("divu_max_1", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    run_op("divu_5_max", 0, 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64'd0, 64'd5, 0);
    run_op("divw_min_1", 1, 1, 64'h0000_0001_8000_0000, 64'd1, 34, 64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    run_op("remuw_7_0", 1, 0, 64'd7, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 0);
    run_op("divw_m7_2", 1, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 34,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("divuw_ffff_2", 1, 0, 64'h0000_0000_FFFF_FFFF, 64'd2, 34, 64'h0000_0000_7FFF_FFFF, 64'd1, 0);
    run_op("divuw_8000_1", 1, 0, 64'h0000_0000_8000_0000, 64'd1, 34, 64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    run_op("divw_ovf", 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 2,
           64'hFFFF_FFFF_8000_0000, 64'd0, 0);

    // flush in cycle 10 of a divu
    bus.divw = 1'b0; bus.div_signed = 1'b0;
    bus.dividend = 64'd1000; bus.divisor = 64'd3; bus.in_valid = 1'b1;
    repeat (10) next_cycle();
    bus.flush = 1'b1; bus.in_valid = 1'b0;
    next_cycle();
    bus.flush = 1'b0;
    check("flush_ready", 64'(bus.out_ready), 64'd1);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (70) begin
      next_cycle();
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_pulse", 64'(seen), 64'd0);
    check("flush_q_held", bus.quotient, 64'hFFFF_FFFF_8000_0000);
    run_op("divu_9_4", 0, 0, 64'd9, 64'd4, 66, 64'd2, 64'd1, 0);

    // flush while IDLE with in_valid must not accept
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.dividend = 64'd50; bus.divisor = 64'd5;
    next_cycle();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_idle_ready", 64'(bus.out_ready), 64'd1);

    // async reset in cycle 20
    bus.dividend = 64'd77; bus.divisor = 64'd3; bus.in_valid = 1'b1;
    repeat (20) next_cycle();
    reset = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("areset_q", bus.quotient, 64'd0);
    check("areset_r", bus.remainder, 64'd0);
    check("areset_ready", 64'(bus.out_ready), 64'd1);
    check("areset_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();

    // back-to-back with in_valid held
    run_op("b2b_a", 0, 0, 64'd100, 64'd7, 66, 64'd14, 64'd2, 1);
    run_op("b2b_b", 0, 0, 64'd9, 64'd4, 66, 64'd2, 64'd1, 1);
    run_op("b2b_c", 1, 1, 64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    run_op("b2b_d", 0, 1, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
